// File: rtl/serial2parallel.sv
// Serial-to-parallel receiver for the three-wire s_clk/s_clr/s_dat shift bus.
// Resynchronises the bus into clk, reassembles DATA_BITS-bit words and hands them off via valid/ack.
module serial2parallel #(
    parameter int DATA_BITS   = 32,
    parameter int CODE_ENDIAN = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_clk,
    input  logic                 s_clr,
    input  logic                 s_dat,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 busy,
    output logic                 overrun,
    output logic                 frame_err
);

    function automatic int get_width(input int value);
        return $clog2(value + 1);
    endfunction

    localparam int CNT_W = get_width(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RECV  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sclr_sync_q, sclr_sync_d;
    logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   sclk_s, sclr_s, sdat_s;
    logic                   sclk_rise_s;
    logic                   word_done_s;
    logic                   abort_s;
    logic [DATA_BITS-1:0]   shifted_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign sclr_s      = sclr_sync_q[SYNC_STAGES-1];
    assign sdat_s      = sdat_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;

    // Next-state logic: synchronisers, frame FSM, shift register and output handshake.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
        sclr_sync_d = {sclr_sync_q[SYNC_STAGES-2:0], s_clr};
        sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], s_dat};
        sclk_prev_d = sclk_s;

        if (CODE_ENDIAN == 0) begin
            shifted_s = {sdat_s, shreg_q[DATA_BITS-1:1]};
        end else begin
            shifted_s = {shreg_q[DATA_BITS-2:0], sdat_s};
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        word_done_s = 1'b0;
        abort_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sclr_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                shreg_d = '0;
                if (!sclr_s) begin
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RECV: begin
                // A clear arriving with a bit edge wins; the bit is dropped.
                if (sclr_s) begin
                    state_d = ST_CLEAR;
                    abort_s = (cnt_q != '0);
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (sclk_rise_s) begin
                    shreg_d = shifted_s;
                    if (cnt_q == LAST_BIT) begin
                        word_done_s = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase

        if (word_done_s) begin
            data_d       = shifted_s;
            data_valid_d = 1'b1;
        end else if (data_valid_q && data_ack) begin
            data_d       = data_q;
            data_valid_d = 1'b0;
        end else begin
            data_d       = data_q;
            data_valid_d = data_valid_q;
        end

        overrun_d   = word_done_s & data_valid_q & ~data_ack;
        frame_err_d = abort_s;
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            sclr_sync_q  <= '0;
            sdat_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sclr_sync_q  <= sclr_sync_d;
            sdat_sync_q  <= sdat_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Bench for serial2parallel: LSB-first and MSB-first receivers share one serial bus;
// expected words are queued as frames are sent and compared when data_valid appears.
module tb_serial2parallel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_clk = 1'b0;
    logic        s_clr = 1'b0;
    logic        s_dat = 1'b0;
    logic        ack0 = 1'b0;
    logic        ack1 = 1'b0;
    logic [31:0] data0, data1;
    logic        dv0, dv1, busy0, busy1, ov0, ov1, fe0, fe1;

    int checks = 0;
    int errors = 0;
    int ov_cnt0 = 0;
    int fe_cnt0 = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    always #5 clk = ~clk;

    serial2parallel #(.DATA_BITS(32), .CODE_ENDIAN(0), .SYNC_STAGES(2)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
        .data(data0), .data_valid(dv0), .data_ack(ack0), .busy(busy0),
        .overrun(ov0), .frame_err(fe0)
    );

    serial2parallel #(.DATA_BITS(32), .CODE_ENDIAN(1), .SYNC_STAGES(2)) dut_msb (
        .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_clr(s_clr), .s_dat(s_dat),
        .data(data1), .data_valid(dv1), .data_ack(ack1), .busy(busy1),
        .overrun(ov1), .frame_err(fe1)
    );

    // Pulse counters for the LSB-first receiver's one-cycle flags.
    always @(posedge clk) begin
        if (ov0) ov_cnt0 <= ov_cnt0 + 1;
        if (fe0) fe_cnt0 <= fe_cnt0 + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] bitrev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk); s_clr = 1'b1;
        repeat (4) @(negedge clk);
        s_clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk); s_clk = 1'b0; s_dat = b;
        repeat (4) @(negedge clk);
        s_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input bit msb, input int first, input int n);
        for (int i = first; i < first + n; i++) send_bit(msb ? w[31-i] : w[i]);
    endtask

    task automatic send_frame(input logic [31:0] w, input bit msb);
        exp_q0.push_back(msb ? bitrev(w) : w);
        exp_q1.push_back(msb ? w : bitrev(w));
        pulse_clr();
        send_bits(w, msb, 0, 32);
    endtask

    task automatic check_word(input string name);
        logic [31:0] e0, e1;
        for (int i = 0; i < 40 && !dv0; i++) @(negedge clk);
        checks++;
        if (dv0 !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout: data_valid=%b required 1", name, dv0);
        end
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_queue: scoreboard empty, got %0d required >0", name, exp_q0.size());
        end else begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            checks++;
            if (data0 !== e0) begin
                errors++;
                $display("FAIL %s_data_lsb: got %h required %h", name, data0, e0);
            end
            checks++;
            if (data1 !== e1 || dv1 !== 1'b1) begin
                errors++;
                $display("FAIL %s_data_msb: got %h/%b required %h/1", name, data1, dv1, e1);
            end
        end
    endtask

    task automatic ack_both(input string name);
        @(negedge clk); ack0 = 1'b1; ack1 = 1'b1;
        @(negedge clk); ack0 = 1'b0; ack1 = 1'b0;
        checks++;
        if (dv0 !== 1'b0 || dv1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_clear: data_valid=%b%b required 00", name, dv0, dv1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data0, dv0, busy0, ov0, fe0} !== 36'd0 || {data1, dv1, busy1, ov1, fe1} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b required all 0", data0, dv0, busy0, ov0, fe0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lsb_frame();
        logic [31:0] w;
        w = 32'hA5C30F81;
        exp_q0.push_back(w);
        exp_q1.push_back(bitrev(w));
        pulse_clr();
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL lsb_busy_after_clr: got %b required 1", busy0);
        end
        send_bits(w, 1'b0, 0, 31);
        @(negedge clk); s_clk = 1'b0; s_dat = w[31];
        repeat (4) @(negedge clk);
        s_clk = 1'b1;
        @(negedge clk);
        checks++;
        if (dv0 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_latency_1: data_valid=%b required 0", dv0);
        end
        @(negedge clk);
        checks++;
        if (dv0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL lsb_latency_2: valid/busy=%b%b required 01", dv0, busy0);
        end
        @(negedge clk);
        checks++;
        if (dv0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_latency_3: valid/busy=%b%b required 10", dv0, busy0);
        end
        check_word("lsb");
        ack_both("lsb");
    endtask

    task automatic test_msb_frame();
        do_reset();
        send_frame(32'h80000001, 1'b1);
        check_word("msb_a");
        ack_both("msb_a");
        send_frame(32'hC0FFEE01, 1'b1);
        check_word("msb_b");
        ack_both("msb_b");
    endtask

    task automatic test_abort_restart();
        int f;
        pulse_clr();
        send_bits(32'h000002B5, 1'b0, 0, 10);
        f = fe_cnt0;
        pulse_clr();
        checks++;
        if (fe_cnt0 - f !== 1) begin
            errors++;
            $display("FAIL abort_frame_err: pulses=%0d required 1", fe_cnt0 - f);
        end
        checks++;
        if (dv0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid: data_valid=%b required 0", dv0);
        end
        f = fe_cnt0;
        send_frame(32'h12345678, 1'b0);
        checks++;
        if (fe_cnt0 != f) begin
            errors++;
            $display("FAIL abort_zero_bit_clr: pulses=%0d required 0", fe_cnt0 - f);
        end
        check_word("restart");
        ack_both("restart");
    endtask

    task automatic test_back_to_back();
        int o;
        o = ov_cnt0;
        send_frame(32'h11111111, 1'b0);
        check_word("b2b_first");
        checks++;
        if (ov_cnt0 != o) begin
            errors++;
            $display("FAIL b2b_first_overrun: pulses=%0d required 0", ov_cnt0 - o);
        end
        send_frame(32'h22222222, 1'b0);
        checks++;
        if (ov_cnt0 - o !== 1) begin
            errors++;
            $display("FAIL b2b_overrun: pulses=%0d required 1", ov_cnt0 - o);
        end
        check_word("b2b_second");
    endtask

    task automatic test_ack_collision();
        logic [31:0] w;
        int o;
        w = 32'h0F1E2D3C;
        o = ov_cnt0;
        exp_q0.push_back(w);
        exp_q1.push_back(bitrev(w));
        pulse_clr();
        send_bits(w, 1'b0, 0, 31);
        @(negedge clk); s_clk = 1'b0; s_dat = w[31];
        repeat (4) @(negedge clk);
        s_clk = 1'b1;
        @(negedge clk);
        @(negedge clk); ack0 = 1'b1; ack1 = 1'b1;
        @(negedge clk); ack0 = 1'b0; ack1 = 1'b0;
        checks++;
        if (dv0 !== 1'b1 || ov0 !== 1'b0) begin
            errors++;
            $display("FAIL collision_valid_overrun: got %b%b required 10", dv0, ov0);
        end
        check_word("collision");
        checks++;
        if (ov_cnt0 != o) begin
            errors++;
            $display("FAIL collision_overrun_count: pulses=%0d required 0", ov_cnt0 - o);
        end
        ack_both("collision");
    endtask

    task automatic test_reset_mid_frame();
        int f;
        pulse_clr();
        send_bits(32'h0000A5A5, 1'b0, 0, 16);
        f = fe_cnt0;
        do_reset();
        checks++;
        if ({data0, dv0, busy0, ov0, fe0} !== 36'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%b%b%b%b required all 0", data0, dv0, busy0, ov0, fe0);
        end
        send_bits(32'hFFFF0000, 1'b0, 0, 16);
        checks++;
        if (dv0 !== 1'b0 || busy0 !== 1'b0 || fe_cnt0 != f) begin
            errors++;
            $display("FAIL midreset_no_clr: valid/busy/fe=%b%b%0d required 000", dv0, busy0, fe_cnt0 - f);
        end
        send_frame(32'hDEADBEEF, 1'b0);
        check_word("midreset_new");
        ack_both("midreset_new");
    endtask

    initial begin
        test_reset();
        test_lsb_frame();
        test_msb_frame();
        test_abort_restart();
        test_back_to_back();
        test_ack_collision();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
